// File: rtl/stump_stream_pkg.sv
// Shared definitions for the Stump stream demultiplexer slice.
// Holds the default data and counter widths and the destination select
// encodings. The select values match the S input of the Stump 2-to-1
// datapath mux: S=0 picks D0, S=1 picks D1.
package stump_stream_pkg;

    localparam int unsigned STUMP_WIDTH = 16;
    localparam int unsigned STUMP_CNT_W = 8;

    localparam logic SEL_D0 = 1'b0;
    localparam logic SEL_D1 = 1'b1;

endpackage : stump_stream_pkg

// File: rtl/stump_stream_slot.sv
// One-entry output register stage with a valid/ready handshake and a
// delivered-word counter.
//
// Ports:
//   clk, rst    - rising-edge clock, asynchronous active-high reset
//   load        - write load_data into the slot on this edge
//   load_data   - word to capture
//   slot_data   - registered slot contents
//   slot_valid  - slot holds a word
//   slot_ready  - consumer accepts the word this cycle
//   slot_count  - words delivered (valid & ready edges), wraps
//   can_load    - slot can take a word this cycle (empty or draining)
module stump_stream_slot
    import stump_stream_pkg::*;
#(
    parameter int unsigned WIDTH = STUMP_WIDTH,
    parameter int unsigned CNT_W = STUMP_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] slot_data,
    output logic             slot_valid,
    input  logic             slot_ready,
    output logic [CNT_W-1:0] slot_count,
    output logic             can_load
);

    logic drain;

    assign drain    = slot_valid & slot_ready;
    // A draining slot can be refilled on the same edge, which keeps one
    // word per cycle flowing through a channel.
    assign can_load = ~slot_valid | slot_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_data  <= '0;
            slot_valid <= 1'b0;
        end else if (load) begin
            slot_data  <= load_data;
            slot_valid <= 1'b1;
        end else if (drain) begin
            slot_valid <= 1'b0;
        end
    end

    // Counts deliveries only; a refill on the same edge does not matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_count <= '0;
        end else if (drain) begin
            slot_count <= slot_count + CNT_W'(1);
        end
    end

endmodule : stump_stream_slot

// File: rtl/stump_demux16bit_stream.sv
// Registered 1-to-2 stream demultiplexer: the inverse of the Stump 16-bit
// 2-to-1 datapath select. Each accepted word is steered by in_sel into one
// of two independent one-entry output slots.
//
// Ports:
//   clk, rst                 - rising-edge clock, async active-high reset
//   in_data, in_sel          - word and destination (0 -> ch0, 1 -> ch1)
//   in_valid, in_ready       - producer handshake; in_ready depends only on
//                              the selected slot's state, not on in_valid
//   out0_data/valid/ready    - channel 0 slot and consumer handshake
//   out1_data/valid/ready    - channel 1 slot and consumer handshake
//   out0_count, out1_count   - words delivered per channel, wrapping
module stump_demux16bit_stream
    import stump_stream_pkg::*;
#(
    parameter int unsigned WIDTH = STUMP_WIDTH,
    parameter int unsigned CNT_W = STUMP_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] out0_count,
    output logic [CNT_W-1:0] out1_count
);

    logic can_load0;
    logic can_load1;
    logic xfer;
    logic load0;
    logic load1;

    // Only the selected slot gates acceptance, so a stalled channel never
    // blocks words bound for the other one.
    always_comb begin
        in_ready = can_load0;
        if (in_sel == SEL_D1) begin
            in_ready = can_load1;
        end
    end

    assign xfer  = in_valid & in_ready;
    assign load0 = xfer & (in_sel == SEL_D0);
    assign load1 = xfer & (in_sel == SEL_D1);

    stump_stream_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot0 (
        .clk        (clk),
        .rst        (rst),
        .load       (load0),
        .load_data  (in_data),
        .slot_data  (out0_data),
        .slot_valid (out0_valid),
        .slot_ready (out0_ready),
        .slot_count (out0_count),
        .can_load   (can_load0)
    );

    stump_stream_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk        (clk),
        .rst        (rst),
        .load       (load1),
        .load_data  (in_data),
        .slot_data  (out1_data),
        .slot_valid (out1_valid),
        .slot_ready (out1_ready),
        .slot_count (out1_count),
        .can_load   (can_load1)
    );

endmodule : stump_demux16bit_stream

// File: tb/tb_stump_demux16bit_stream.sv
// Self-checking bench for stump_demux16bit_stream. Stimulus pushes the
// expected word into a per-channel queue when a transfer is committed; a
// monitor pops and compares whenever a channel delivers a word.
module tb_stump_demux16bit_stream;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [15:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [7:0]  out0_count;
    logic [7:0]  out1_count;

    int checks_total;
    int checks_passed;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    stump_demux16bit_stream #(
        .WIDTH (16),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out0_count (out0_count),
        .out1_count (out1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a delivery happens on the next posedge when valid & ready
    // are both high at the preceding negedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out0_valid && out0_ready) begin
                if (q0.size() == 0) begin
                    chk("ch0_unexpected_word", 32'(out0_data), 32'hFFFF_FFFF);
                end else begin
                    chk("ch0_data", 32'(out0_data), 32'(q0.pop_front()));
                end
            end
            if (out1_valid && out1_ready) begin
                if (q1.size() == 0) begin
                    chk("ch1_unexpected_word", 32'(out1_data), 32'hFFFF_FFFF);
                end else begin
                    chk("ch1_data", 32'(out1_data), 32'(q1.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and wait (bounded) for it to be accepted.
    task automatic send(input logic [15:0] d, input logic s);
        bit done;
        done     = 1'b0;
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (s) q1.push_back(d);
                else   q0.push_back(d);
                done = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'(d), 32'hFFFF_FFFF);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst        = 1'b1;
        in_data    = '0;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state after release
        @(negedge clk);
        chk("rst_out0_valid", 32'(out0_valid), 32'd0);
        chk("rst_out1_valid", 32'(out1_valid), 32'd0);
        chk("rst_in_ready",   32'(in_ready),   32'd1);
        tick();

        // Asynchronous reset mid-cycle while ch0 holds a word
        send(16'h1234, 1'b0);
        chk("pre_rst_out0_valid", 32'(out0_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out0_valid", 32'(out0_valid), 32'd0);
        chk("arst_out1_valid", 32'(out1_valid), 32'd0);
        chk("arst_out0_data",  32'(out0_data),  32'h0000);
        chk("arst_out1_data",  32'(out1_data),  32'h0000);
        chk("arst_out0_count", 32'(out0_count), 32'd0);
        chk("arst_out1_count", 32'(out1_count), 32'd0);
        chk("arst_in_ready",   32'(in_ready),   32'd1);
        q0.delete();
        tick();
        rst = 1'b0;
        tick();

        // Single steer to ch1, held 5 cycles, then delivered
        send(16'hA5A5, 1'b1);
        chk("steer_out1_valid", 32'(out1_valid), 32'd1);
        chk("steer_out1_data",  32'(out1_data),  32'hA5A5);
        chk("steer_out0_valid", 32'(out0_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("steer_hold_data", 32'(out1_data), 32'hA5A5);
            chk("steer_hold_valid", 32'(out1_valid), 32'd1);
        end
        out1_ready = 1'b1;
        tick();
        out1_ready = 1'b0;
        chk("steer_drained_valid", 32'(out1_valid), 32'd0);
        chk("steer_out1_count",    32'(out1_count), 32'd1);

        // Back-pressure isolation
        send(16'h1111, 1'b0);
        in_data  = 16'h2222;
        in_sel   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_sel0", 32'(in_ready), 32'd0);
        tick();
        chk("bp_out0_still_1111", 32'(out0_data), 32'h1111);
        in_data = 16'h3333;
        in_sel  = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_sel1", 32'(in_ready), 32'd1);
        if (in_ready) q1.push_back(16'h3333);
        tick();
        in_valid = 1'b0;
        chk("bp_out1_data",  32'(out1_data),  32'h3333);
        chk("bp_out1_valid", 32'(out1_valid), 32'd1);
        chk("bp_out0_data",  32'(out0_data),  32'h1111);
        chk("bp_out0_valid", 32'(out0_valid), 32'd1);
        // Both channels drain on the same edge
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        tick();
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        chk("dual_drain_out0_valid", 32'(out0_valid), 32'd0);
        chk("dual_drain_out1_valid", 32'(out1_valid), 32'd0);
        chk("dual_drain_out0_count", 32'(out0_count), 32'd1);
        chk("dual_drain_out1_count", 32'(out1_count), 32'd2);

        // Full throughput on ch0: 16 words back to back
        out0_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_data  = 16'(i);
            in_sel   = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
            chk("tput_in_ready", 32'(in_ready), 32'd1);
            if (in_ready) q0.push_back(16'(i));
            tick();
            chk("tput_latency_data", 32'(out0_data), 32'(i));
        end
        in_valid = 1'b0;
        tick();
        out0_ready = 1'b0;
        chk("tput_out0_valid", 32'(out0_valid), 32'd0);
        chk("tput_out0_count", 32'(out0_count), 32'd17);

        // Simultaneous drain and load on ch1
        send(16'hBEEF, 1'b1);
        chk("dl_pre_data", 32'(out1_data), 32'hBEEF);
        out1_ready = 1'b1;
        in_data    = 16'hCAFE;
        in_sel     = 1'b1;
        in_valid   = 1'b1;
        @(negedge clk);
        chk("dl_in_ready", 32'(in_ready), 32'd1);
        if (in_ready) q1.push_back(16'hCAFE);
        tick();
        in_valid   = 1'b0;
        out1_ready = 1'b0;
        chk("dl_out1_valid", 32'(out1_valid), 32'd1);
        chk("dl_out1_data",  32'(out1_data),  32'hCAFE);
        chk("dl_out1_count", 32'(out1_count), 32'd3);
        out1_ready = 1'b1;
        tick();
        out1_ready = 1'b0;
        chk("dl_final_count", 32'(out1_count), 32'd4);

        // Counter wrap on ch0, from a fresh reset
        do_reset();
        // Empty slot with ready high: no delivery, no count
        out1_ready = 1'b1;
        tick();
        tick();
        chk("empty_ready_count", 32'(out1_count), 32'd0);
        chk("empty_ready_valid", 32'(out1_valid), 32'd0);
        out1_ready = 1'b0;
        out0_ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            send(16'(16'h4000 + i), 1'b0);
        end
        tick();
        chk("wrap_count_255", 32'(out0_count), 32'h0000_00FF);
        send(16'h5AA5, 1'b0);
        tick();
        chk("wrap_count_256", 32'(out0_count), 32'h0000_0000);
        send(16'hA55A, 1'b0);
        tick();
        chk("wrap_count_257", 32'(out0_count), 32'h0000_0001);
        out0_ready = 1'b0;

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule : tb_stump_demux16bit_stream

// File: doc/stump_demux16bit_stream.md
Name: stump_demux16bit_stream

Overview:
- Registered 1-to-2 stream demultiplexer; the inverse of the Stump 16-bit 2-to-1 datapath select.
- Takes one 16-bit word per handshake and steers it, by a select bit, into one of two one-entry output slots.
- Each slot has its own valid/ready handshake and its own delivered-word counter.
- Sits between a producer (e.g. ALU result or memory read-data path) and two independent consumers (e.g. register-file write path vs. memory write-data path).

Parameters:
- WIDTH, 16, data word width.
- CNT_W, 8, width of each per-channel delivered-word counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  word to be steered.
- in_sel  input  1  destination: 0 -> channel 0 (D0), 1 -> channel 1 (D1).
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- out0_data  output  WIDTH  channel 0 slot data.
- out0_valid  output  1  channel 0 slot holds a word.
- out0_ready  input  1  channel 0 consumer accepts.
- out1_data  output  WIDTH  channel 1 slot data.
- out1_valid  output  1  channel 1 slot holds a word.
- out1_ready  input  1  channel 1 consumer accepts.
- out0_count  output  CNT_W  words delivered on channel 0.
- out1_count  output  CNT_W  words delivered on channel 1.

Behaviour:
- Reset: one clock, asynchronous active-high. While rst=1: outN_valid=0, outN_data=0, outN_count=0. in_ready is combinational and therefore reads 1 during reset.
- Words held in slots at reset assertion are discarded; no partial state survives.
- Input accept: in_ready = !outS_valid | outS_ready, where S = in_sel.
  - Purely combinational from in_sel, out*_valid and out*_ready; no dependence on in_valid.
  - Transfer occurs when in_valid & in_ready.
- Latency: a word accepted at edge k is presented on outS_data with outS_valid=1 from edge k onward, i.e. 1 cycle after acceptance. No combinational path from in_data to outN_data.
- Slot N, next-state per edge, in priority order:
  - Load (transfer with S=N): data <= in_data, valid <= 1. This applies even if the slot drains on the same edge, giving full throughput of 1 word/cycle per channel.
  - Drain only (outN_valid & outN_ready, no load): valid <= 0; data is retained, don't-care.
  - Otherwise: hold. data must stay stable while valid=1 and ready=0.
- Channels are independent:
  - A stalled channel never blocks input destined for the other channel.
  - Both slots may drain on the same edge.
  - At most one slot loads per edge.
- in_sel is sampled only at transfer; changing it while in_valid=1 and in_ready=0 is legal, and in_ready follows the new select.
- Counters: outN_count increments by 1 on each edge with outN_valid & outN_ready, and wraps modulo 2^CNT_W (max value -> 0). A simultaneous load on the same edge does not affect the count.
- Full channel (valid=1, ready=0) with in_valid=1 targeting it: in_ready=0; producer must hold in_data and in_sel.
- Empty output with out_ready=1: no effect, no count.

Decomposition:
- Shared package stump_stream_pkg holds:
  - WIDTH default (16).
  - Select encodings SEL_D0=1'b0, SEL_D1=1'b1, matching the existing mux S convention.
  - CNT_W default.
- One natural sub-module, stump_stream_slot: a one-entry register stage with load, drain, valid, ready-through and counter. Instantiated twice. The top level holds only the in_ready select and the load decode.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with out0_valid=1 -> out0_valid, out1_valid = 0 immediately; data = 16'h0000; counts = 0; in_ready = 1.
- Single steer: in_data=16'hA5A5, in_sel=1, in_valid=1 for one cycle, out1_ready=0 -> next cycle out1_valid=1, out1_data=16'hA5A5, out0_valid=0. Data held 5 cycles; then out1_ready=1 for one cycle -> out1_valid=0, out1_count=1.
- Back-pressure isolation: fill ch0 with 16'h1111, out0_ready=0; present 16'h2222 sel=0 -> in_ready=0. Switch to sel=1 with 16'h3333 -> in_ready=1 and out1_data=16'h3333 next cycle; out0_data still 16'h1111.
- Full throughput: out0_ready=1 held; stream 16'h0001..16'h0010, sel=0, every cycle -> in_ready stays 1; each word appears exactly 1 cycle after acceptance, in order; out0_count=16.
- Simultaneous drain+load: ch1 full with 16'hBEEF, out1_ready=1, new 16'hCAFE sel=1 same cycle -> out1_valid remains 1, out1_data=16'hCAFE, out1_count +1.
- Counter wrap (CNT_W=8): deliver 256 words on ch0 -> out0_count returns to 8'h00; 257th word -> 8'h01.
